// File: rtl/vm_pkg.sv
// Shared definitions for the change dispenser: coin indices, values and FSM states.
package vm_pkg;

    localparam int NUM_COINS = 6;

    localparam logic [2:0] COIN_50 = 3'd0;
    localparam logic [2:0] COIN_20 = 3'd1;
    localparam logic [2:0] COIN_10 = 3'd2;
    localparam logic [2:0] COIN_5  = 3'd3;
    localparam logic [2:0] COIN_2  = 3'd4;
    localparam logic [2:0] COIN_1  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SELECT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_FINISH   = 2'd3
    } state_t;

    typedef logic [NUM_COINS-1:0][3:0] stock_vec_t;

    // Face value of a coin index; indices outside the table are worth nothing.
    function automatic logic [6:0] coin_value(input logic [2:0] idx);
        case (idx)
            COIN_50: coin_value = 7'd50;
            COIN_20: coin_value = 7'd20;
            COIN_10: coin_value = 7'd10;
            COIN_5:  coin_value = 7'd5;
            COIN_2:  coin_value = 7'd2;
            COIN_1:  coin_value = 7'd1;
            default: coin_value = 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_select.sv
// Picks the largest in-stock coin that does not exceed the remaining change.
module coin_select
    import vm_pkg::*;
(
    input  logic [6:0] rem,
    input  stock_vec_t stock,
    output logic       found,
    output logic [2:0] idx
);

    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        found = 1'b0;
        idx   = 3'd0;
        // Walk from the smallest coin upward so the largest eligible one is written last.
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (stock[i] != 4'd0 && coin_value(3'(i)) <= rem) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested amount coin by coin from limited stocks,
// reporting any shortfall through redLight and owed.
module change_dispenser
    import vm_pkg::*;
#(
    parameter logic [3:0] STOCK_INIT = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] change_in,
    input  logic       refill,
    input  logic       coin_ready,
    output logic       coin_valid,
    output logic [2:0] coin_type,
    output logic       busy,
    output logic       done,
    output logic       redLight,
    output logic [6:0] owed,
    output logic       stock_empty
);

    state_t     state;
    logic [6:0] rem;
    stock_vec_t stock;
    logic       sel_found;
    logic [2:0] sel_idx;

    coin_select u_coin_select (
        .rem   (rem),
        .stock (stock),
        .found (sel_found),
        .idx   (sel_idx)
    );

    // Outputs decoded from state so an asynchronous reset drops them at once.
    assign coin_valid = (state == S_DISPENSE);
    assign done       = (state == S_FINISH);
    assign busy       = (state != S_IDLE);

    always_comb begin
        stock_empty = 1'b0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (stock[i] == 4'd0) stock_empty = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the six stock counters are plain flops, not a RAM, so they reset directly.
            state     <= S_IDLE;
            rem       <= 7'd0;
            stock     <= {NUM_COINS{STOCK_INIT}};
            coin_type <= 3'd0;
            redLight  <= 1'b0;
            owed      <= 7'd0;
        end else begin
            // NOTE: non-blocking so every register sees the pre-edge values of the others.
            case (state)
                S_IDLE: begin
                    if (refill) stock <= {NUM_COINS{STOCK_INIT}};
                    if (start) begin
                        rem      <= change_in;
                        redLight <= 1'b0;
                        state    <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (rem != 7'd0 && sel_found) begin
                        coin_type <= sel_idx;
                        state     <= S_DISPENSE;
                    end else begin
                        state <= S_FINISH;
                    end
                end
                S_DISPENSE: begin
                    if (coin_ready) begin
                        rem              <= rem - coin_value(coin_type);
                        stock[coin_type] <= stock[coin_type] - 4'd1;
                        state            <= S_SELECT;
                    end
                end
                S_FINISH: begin
                    owed     <= rem;
                    redLight <= (rem != 7'd0);
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench: greedy payout model plus directed scenarios on two stock sizes.
module tb_change_dispenser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_start, a_refill, a_ready, b_start, b_refill, b_ready;
    logic [6:0] a_change, b_change;
    logic       a_cv, a_busy, a_done, a_red, a_se;
    logic       b_cv, b_busy, b_done, b_red, b_se;
    logic [2:0] a_ct, b_ct;
    logic [6:0] a_owed, b_owed;

    change_dispenser dut_a (
        .clk(clk), .rst(rst), .start(a_start), .change_in(a_change), .refill(a_refill),
        .coin_ready(a_ready), .coin_valid(a_cv), .coin_type(a_ct), .busy(a_busy),
        .done(a_done), .redLight(a_red), .owed(a_owed), .stock_empty(a_se)
    );

    change_dispenser #(.STOCK_INIT(4'd1)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .change_in(b_change), .refill(b_refill),
        .coin_ready(b_ready), .coin_valid(b_cv), .coin_type(b_ct), .busy(b_busy),
        .done(b_done), .redLight(b_red), .owed(b_owed), .stock_empty(b_se)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: greedy payout over explicit stock counts, planned whole at start time.
    int vals [6] = '{50, 20, 10, 5, 2, 1};
    int mstock_a [6];
    int mstock_b [6];
    int expq_a [$];
    int expq_b [$];
    int cap_a [$];
    int cap_b [$];
    int exp_owed_a, exp_owed_b;

    task automatic plan_a(input int change);
        int  rem = change;
        bit  hit;
        expq_a.delete();
        do begin
            hit = 0;
            for (int i = 0; i < 6 && !hit; i++) begin
                if (vals[i] <= rem && mstock_a[i] > 0) begin
                    hit = 1;
                    expq_a.push_back(i);
                    rem -= vals[i];
                    mstock_a[i]--;
                end
            end
        end while (hit);
        exp_owed_a = rem;
    endtask

    task automatic plan_b(input int change);
        int  rem = change;
        bit  hit;
        expq_b.delete();
        do begin
            hit = 0;
            for (int i = 0; i < 6 && !hit; i++) begin
                if (vals[i] <= rem && mstock_b[i] > 0) begin
                    hit = 1;
                    expq_b.push_back(i);
                    rem -= vals[i];
                    mstock_b[i]--;
                end
            end
        end while (hit);
        exp_owed_b = rem;
    endtask

    // Per-cycle compare against the model queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_cv) begin
                if (expq_a.size() == 0) check("a_unexpected_coin", 1, 0);
                else check("a_coin_type", a_ct, expq_a[0]);
                if (a_ready) begin
                    cap_a.push_back(int'(a_ct));
                    if (expq_a.size() > 0) void'(expq_a.pop_front());
                end
            end
            if (a_done) check("a_coins_left_at_done", expq_a.size(), 0);
            if (b_cv) begin
                if (expq_b.size() == 0) check("b_unexpected_coin", 1, 0);
                else check("b_coin_type", b_ct, expq_b[0]);
                if (b_ready) begin
                    cap_b.push_back(int'(b_ct));
                    if (expq_b.size() > 0) void'(expq_b.pop_front());
                end
            end
            if (b_done) check("b_coins_left_at_done", expq_b.size(), 0);
        end
    end

    task automatic go_a(input int change, input bit rf);
        @(posedge clk); #1;
        a_change = 7'(change); a_start = 1'b1; a_refill = rf;
        @(posedge clk); #1;
        a_start = 1'b0; a_refill = 1'b0;
    endtask

    task automatic go_b(input int change);
        @(posedge clk); #1;
        b_change = 7'(change); b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (a_done) seen = 1;
        end
        check("a_done_timeout", seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done_b(input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (b_done) seen = 1;
        end
        check("b_done_timeout", seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_stocks_a(input string name);
        for (int i = 0; i < 6; i++) check(name, dut_a.stock[i], mstock_a[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen_done;
        rst = 1'b1;
        a_start = 0; a_refill = 0; a_ready = 1; a_change = 0;
        b_start = 0; b_refill = 0; b_ready = 1; b_change = 0;
        for (int i = 0; i < 6; i++) begin mstock_a[i] = 15; mstock_b[i] = 1; end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_coin_valid", a_cv, 0);
        check("rst_coin_type", a_ct, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_redlight", a_red, 0);
        check("rst_owed", a_owed, 0);
        check("rst_stock_empty_a", a_se, 0);
        check("rst_stock_empty_b", b_se, 0);
        rst = 1'b0;

        // 87 with full stock: 50 20 10 5 2
        plan_a(87);
        check("model_87_count", expq_a.size(), 5);
        check("model_87_owed", exp_owed_a, 0);
        cap_a.delete();
        go_a(87, 0);
        wait_done_a(40);
        check("p87_owed", a_owed, 0);
        check("p87_redlight", a_red, 0);
        check("p87_coin_count", cap_a.size(), 5);
        for (int i = 0; i < cap_a.size() && i < 5; i++) check("p87_coin_seq", cap_a[i], i);
        for (int i = 0; i < 5; i++) check("p87_stock_lit", dut_a.stock[i], 14);
        check("p87_stock1_lit", dut_a.stock[5], 15);

        // Zero payout: done exactly two cycles after start
        plan_a(0);
        go_a(0, 0);
        @(negedge clk);
        check("z_busy_c1", a_busy, 1);
        check("z_done_c1", a_done, 0);
        check("z_valid_c1", a_cv, 0);
        @(negedge clk);
        check("z_done_c2", a_done, 1);
        check("z_busy_c2", a_busy, 1);
        check("z_valid_c2", a_cv, 0);
        @(negedge clk);
        check("z_done_c3", a_done, 0);
        check("z_busy_c3", a_busy, 0);
        check("z_owed", a_owed, 0);
        check("z_redlight", a_red, 0);

        // 20 with coin_ready stalled for three cycles
        a_ready = 1'b0;
        plan_a(20);
        check("model_20_count", expq_a.size(), 1);
        cap_a.delete();
        go_a(20, 0);
        @(negedge clk);
        check("s_valid_select", a_cv, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s_valid_stall", a_cv, 1);
            check("s_type_stall", a_ct, 1);
        end
        @(posedge clk); #1;
        a_ready = 1'b1;
        @(negedge clk);
        check("s_valid_accept", a_cv, 1);
        check("s_type_accept", a_ct, 1);
        @(negedge clk);
        check("s_valid_after", a_cv, 0);
        wait_done_a(20);
        check("s_coin_count", cap_a.size(), 1);
        check("s_owed", a_owed, 0);
        check_stocks_a("s_stock");

        // STOCK_INIT=1, 100: shortfall of 12
        plan_b(100);
        check("model_100_count", expq_b.size(), 6);
        check("model_100_owed", exp_owed_b, 12);
        cap_b.delete();
        go_b(100);
        wait_done_b(60);
        check("b_owed", b_owed, 12);
        check("b_redlight", b_red, 1);
        check("b_stock_empty", b_se, 1);
        check("b_coin_count", cap_b.size(), 6);
        for (int i = 0; i < cap_b.size() && i < 6; i++) check("b_coin_seq", cap_b[i], i);
        b_refill = 1'b1;
        @(posedge clk); #1;
        b_refill = 1'b0;
        for (int i = 0; i < 6; i++) mstock_b[i] = 1;
        @(negedge clk);
        check("b_refill_empty", b_se, 0);
        check("b_red_holds", b_red, 1);
        check("b_owed_holds", b_owed, 12);

        // Reset in the second DISPENSE cycle of 87
        a_ready = 1'b0;
        plan_a(87);
        go_a(87, 0);
        @(negedge clk);
        @(negedge clk);
        check("r_valid_disp1", a_cv, 1);
        @(posedge clk); #1;
        check("r_valid_disp2", a_cv, 1);
        rst = 1'b1;
        #1;
        check("r_valid_async", a_cv, 0);
        check("r_busy_async", a_busy, 0);
        for (int i = 0; i < 6; i++) check("r_stock_lit", dut_a.stock[i], 15);
        expq_a.delete();
        for (int i = 0; i < 6; i++) begin mstock_a[i] = 15; mstock_b[i] = 1; end
        @(posedge clk); #1;
        rst = 1'b0;
        a_ready = 1'b1;
        seen_done = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (a_done) seen_done = 1;
        end
        check("r_no_done", seen_done, 0);

        // start/refill pulsed while busy are ignored
        plan_a(87);
        go_a(87, 0);
        wait_done_a(40);
        plan_a(20);
        cap_a.delete();
        go_a(20, 0);
        a_change = 7'd50; a_start = 1'b1; a_refill = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; a_refill = 1'b0;
        wait_done_a(20);
        check("i_coin_count", cap_a.size(), 1);
        if (cap_a.size() > 0) check("i_coin_type", cap_a[0], 1);
        check("i_owed", a_owed, 0);
        check("i_busy_after", a_busy, 0);
        check_stocks_a("i_stock");

        // refill together with start: reload then pay 10
        for (int i = 0; i < 6; i++) mstock_a[i] = 15;
        plan_a(10);
        go_a(10, 1);
        wait_done_a(20);
        check_stocks_a("rs_stock");
        check("rs_stock10_lit", dut_a.stock[2], 14);
        check("rs_owed", a_owed, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
